// File: rtl/downmixer_decim_if.sv
// Sample-stream bundle for the mix-down decimator: input samples with LO, decimated output and status.
interface downmixer_decim_if #(
    parameter int DATA_W = 20
);
    logic                     clear;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] lo;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     overflow;

    modport master (
        output clear, in_valid, in_data, lo,
        input  out_valid, out_data, overflow
    );

    modport slave (
        input  clear, in_valid, in_data, lo,
        output out_valid, out_data, overflow
    );
endinterface

// File: rtl/downmixer_decim.sv
// Mix-down by LO, then accumulate-and-dump decimation with a saturated baseband output.
// Latency 2 clocks from the final sample of a block; always ready, no backpressure.
module downmixer_decim #(
    parameter int DATA_W     = 20,
    parameter int FRAC       = 14,
    parameter int DECIM_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    downmixer_decim_if.slave  bus
);
    localparam int P_W   = 2*DATA_W - FRAC;
    localparam int ACC_W = P_W + DECIM_LOG2;
    localparam int HI_W  = ACC_W - DATA_W + 1;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [P_W-1:0]      p_nxt;
    logic signed [P_W-1:0]      p;
    logic                       p_valid;
    logic signed [ACC_W-1:0]    acc;
    logic [DECIM_LOG2-1:0]      count;

    logic signed [ACC_W-1:0]    p_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    s;
    logic [HI_W-1:0]            s_hi;
    logic                       sat;
    logic signed [DATA_W-1:0]   sat_val;
    logic                       dump;

    // Dropping the low FRAC bits of the full product is an arithmetic shift (floor).
    assign prod  = bus.in_data * bus.lo;
    assign p_nxt = prod[2*DATA_W-1:FRAC];

    assign p_ext = {{DECIM_LOG2{p[P_W-1]}}, p};
    assign sum   = acc + p_ext;
    assign s     = sum >>> DECIM_LOG2;
    assign dump  = p_valid && (count == '1);

    // The value fits the output only if every bit above the output sign bit copies it.
    always_comb begin
        s_hi    = s[ACC_W-1:DATA_W-1];
        sat     = !((&s_hi) || !(|s_hi));
        sat_val = s[DATA_W-1:0];
        if (sat) begin
            sat_val = s[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p       <= '0;
            p_valid <= 1'b0;
        end else if (bus.clear) begin
            p_valid <= 1'b0;
        end else begin
            p_valid <= bus.in_valid;
            if (bus.in_valid) begin
                p <= p_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.overflow  <= 1'b0;
        end else if (bus.clear) begin
            acc           <= '0;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.out_valid <= dump;
            if (dump) begin
                acc          <= '0;
                count        <= '0;
                bus.out_data <= sat_val;
                if (sat) begin
                    bus.overflow <= 1'b1;
                end
            end else if (p_valid) begin
                acc   <= sum;
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_downmixer_decim.sv
// Bench for downmixer_decim: directed and random stimulus against a sample-list reference model.
module tb_downmixer_decim;
    localparam int DW   = 20;
    localparam int FRAC = 14;
    localparam int DL   = 3;
    localparam int N    = 1 << DL;
    localparam longint MAXV = (longint'(1) << (DW-1)) - 1;
    localparam longint MINV = -(longint'(1) << (DW-1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    downmixer_decim_if #(.DATA_W(DW)) bus();

    downmixer_decim #(.DATA_W(DW), .FRAC(FRAC), .DECIM_LOG2(DL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint fdiv(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    // Reference: samples collected per block; expected output state after each edge.
    longint blk[$];
    longint prev    = 0;
    bit     have_prev = 0;
    bit     exp_vld = 0;
    bit     exp_ovf = 0;
    longint exp_dat = 0;

    initial begin
        longint s;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                blk.delete();
                have_prev = 0;
                exp_vld   = 0;
                exp_ovf   = 0;
                exp_dat   = 0;
            end else if (bus.clear) begin
                blk.delete();
                have_prev = 0;
                exp_vld   = 0;
                exp_ovf   = 0;
            end else begin
                exp_vld = 0;
                if (have_prev) begin
                    blk.push_back(prev);
                    if (blk.size() == N) begin
                        s = 0;
                        foreach (blk[i]) s += blk[i];
                        s = fdiv(s, N);
                        if (s > MAXV) begin
                            s = MAXV;
                            exp_ovf = 1;
                        end else if (s < MINV) begin
                            s = MINV;
                            exp_ovf = 1;
                        end
                        exp_dat = s;
                        exp_vld = 1;
                        blk.delete();
                    end
                end
                have_prev = bus.in_valid;
                if (bus.in_valid)
                    prev = fdiv(longint'(bus.in_data) * longint'(bus.lo), longint'(1) << FRAC);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_vld});
            chk("out_data", 64'(bus.out_data), 64'(exp_dat));
            chk("overflow", {63'd0, bus.overflow}, {63'd0, exp_ovf});
        end
    end

    task automatic drive(input logic v, input logic signed [DW-1:0] a,
                         input logic signed [DW-1:0] b, input logic clr);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = a;
        bus.lo       = b;
        bus.clear    = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic send_block(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        repeat (N) drive(1'b1, a, b, 1'b0);
    endtask

    initial begin
        logic signed [DW-1:0] ra;
        logic signed [DW-1:0] rb;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.lo       = '0;
        bus.clear    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_out_data", 64'(bus.out_data), 64'd0);
        chk("reset_overflow", {63'd0, bus.overflow}, 64'd0);
        rst_n = 1'b1;
        idle(2);

        send_block(20'sd16384, 20'sd16384);
        idle(4);
        send_block(-20'sd16384, 20'sd16384);
        idle(3);
        send_block(20'sd1, 20'sd16383);
        idle(3);
        send_block(-20'sd1, 20'sd16383);
        idle(3);
        for (int i = 0; i < N; i++)
            drive(1'b1, 20'sd16384, (i % 2 == 0) ? 20'sd16384 : -20'sd16384, 1'b0);
        idle(3);

        send_block(-20'sd524288, -20'sd524288);
        idle(3);
        send_block(20'sd16384, 20'sd16384);
        idle(3);
        drive(1'b0, '0, '0, 1'b1);
        idle(3);

        for (int i = 0; i < N; i++) begin
            drive(1'b1, 20'sd8192, 20'sd16384, 1'b0);
            idle($urandom_range(0, 4));
        end
        idle(3);
        for (int i = 0; i < N-1; i++) drive(1'b1, 20'sd8192, 20'sd16384, 1'b0);
        drive(1'b1, 20'sd8192, 20'sd16384, 1'b1);
        send_block(20'sd4096, 20'sd16384);
        drive(1'b0, '0, '0, 1'b1);
        idle(3);
        send_block(20'sd8192, 20'sd16384);
        idle(3);

        send_block(-20'sd524288, -20'sd524288);
        repeat (5) drive(1'b1, 20'sd32767, 20'sd16384, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("async_rst_out_data", 64'(bus.out_data), 64'd0);
        chk("async_rst_overflow", {63'd0, bus.overflow}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_block(20'sd8192, 20'sd16384);
        idle(4);

        for (int i = 0; i < 800; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            if ($urandom_range(0, 1) == 0) ra = ra >>> 6;
            drive($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 40) == 0);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
